// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing defaults, total-length helper and the flag bundle
// with its flushed (inactive) value used by the delay line.
package vga_pkg;

    localparam int DEF_CNT_W = 10;
    localparam int DEF_HVID  = 640;
    localparam int DEF_HFP   = 16;
    localparam int DEF_HSW   = 96;
    localparam int DEF_HBP   = 48;
    localparam int DEF_VVID  = 480;
    localparam int DEF_VFP   = 10;
    localparam int DEF_VSW   = 2;
    localparam int DEF_VBP   = 33;

    typedef struct packed {
        logic frame;
        logic line;
        logic vblank;
        logic hblank;
        logic bright;
        logic vsync;
        logic hsync;
    } flags_t;

    function automatic int total(input int vid, input int fp, input int sw, input int bp);
        return vid + fp + sw + bp;
    endfunction

    // Syncs idle at the opposite of their active level; everything else idles low.
    function automatic flags_t flush_flags(input logic hs_pol, input logic vs_pol);
        flags_t f;
        f = '0;
        f.hsync = ~hs_pol;
        f.vsync = ~vs_pol;
        return f;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit x D-deep enabled shift register with synchronous flush;
// D=0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int           W    = 1,
    parameter int           D    = 0,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clock,
    input  logic         flush,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (D == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = &{1'b0, clock, flush, en};
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] stage_q [D];
        always_ff @(posedge clock) begin
            if (flush) begin
                for (int i = 0; i < D; i++) stage_q[i] <= INIT;
            end else if (en) begin
                stage_q[0] <= d;
                for (int i = 1; i < D; i++) stage_q[i] <= stage_q[i-1];
            end
        end
        assign q = stage_q[D-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enable driven raster counters, flag decode and a delay line
// that keeps syncs/blank/strobes aligned with a downstream pixel pipeline.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   CNT_W    = DEF_CNT_W,
    parameter int   HVID     = DEF_HVID,
    parameter int   HFP      = DEF_HFP,
    parameter int   HSW      = DEF_HSW,
    parameter int   HBP      = DEF_HBP,
    parameter int   VVID     = DEF_VVID,
    parameter int   VFP      = DEF_VFP,
    parameter int   VSW      = DEF_VSW,
    parameter int   VBP      = DEF_VBP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PIPE_DLY = 0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             pixEn,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             bright,
    output logic             hBlank,
    output logic             vBlank,
    output logic             lineStart,
    output logic             frameStart
);

    localparam int HTOTAL = total(HVID, HFP, HSW, HBP);
    localparam int VTOTAL = total(VVID, VFP, VSW, VBP);

    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be 0..7");
    end
    if (HTOTAL > (1 << CNT_W) || VTOTAL > (1 << CNT_W)) begin : g_bad_tot
        $error("vga_timing_gen: HTOTAL/VTOTAL exceed counter range");
    end

    // One extra bit keeps sync-end bounds representable when a total hits 2**CNT_W.
    localparam logic [CNT_W:0] H_MAX = (CNT_W+1)'(HTOTAL - 1);
    localparam logic [CNT_W:0] H_VID = (CNT_W+1)'(HVID);
    localparam logic [CNT_W:0] H_SS  = (CNT_W+1)'(HVID + HFP);
    localparam logic [CNT_W:0] H_SE  = (CNT_W+1)'(HVID + HFP + HSW);
    localparam logic [CNT_W:0] V_MAX = (CNT_W+1)'(VTOTAL - 1);
    localparam logic [CNT_W:0] V_VID = (CNT_W+1)'(VVID);
    localparam logic [CNT_W:0] V_SS  = (CNT_W+1)'(VVID + VFP);
    localparam logic [CNT_W:0] V_SE  = (CNT_W+1)'(VVID + VFP + VSW);
    localparam flags_t FLUSH = flush_flags(HS_POL, VS_POL);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [CNT_W:0]   h_x, v_x;
    logic             h_wrap, v_wrap;
    flags_t           f0, fd;

    assign h_x    = {1'b0, h_q};
    assign v_x    = {1'b0, v_q};
    assign h_wrap = h_x == H_MAX;
    assign v_wrap = v_x == V_MAX;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (clear) begin
            h_d = '0;
            v_d = '0;
        end else if (pixEn) begin
            h_d = h_wrap ? '0 : h_q + CNT_W'(1);
            v_d = !h_wrap ? v_q : v_wrap ? '0 : v_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        h_q <= h_d;
        v_q <= v_d;
    end

    always_comb begin
        f0.hsync  = (h_x >= H_SS && h_x < H_SE) ? HS_POL : ~HS_POL;
        f0.vsync  = (v_x >= V_SS && v_x < V_SE) ? VS_POL : ~VS_POL;
        f0.bright = h_x < H_VID && v_x < V_VID;
        f0.hblank = h_x >= H_VID;
        f0.vblank = v_x >= V_VID;
        f0.line   = h_q == '0;
        f0.frame  = h_q == '0 && v_q == '0;
    end

    vga_delay_line #(
        .W    ($bits(flags_t)),
        .D    (PIPE_DLY),
        .INIT (FLUSH)
    ) u_dly (
        .clock (clock),
        .flush (clear),
        .en    (pixEn),
        .d     (f0),
        .q     (fd)
    );

    assign hCount = h_q;
    assign vCount = v_q;
    assign hSync  = fd.hsync;
    assign vSync  = fd.vsync;
    assign bright = fd.bright;
    assign hBlank = fd.hblank;
    assign vBlank = fd.vblank;
    // Strobes exist only on ticks, so they never stretch over held cycles.
    assign lineStart  = fd.line & pixEn & ~clear;
    assign frameStart = fd.frame & pixEn & ~clear;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: four configurations driven by shared stimulus, checked every cycle
// against a tick-count raster model plus literal timing expectations.
module tb_vga_timing_gen;

    logic clock = 1'b0;
    logic clear = 1'b1;
    logic pixEn = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int n = 0;
    bit armed = 1'b0;

    logic [3:0] h0, v0, hp, vp;
    logic [4:0] h3, v3;
    logic [9:0] hd, vd;
    logic hs0, vs0, br0, hb0, vb0, ls0, fs0;
    logic hs3, vs3, br3, hb3, vb3, ls3, fs3;
    logic hsp, vsp, brp, hbp, vbp, lsp, fsp;
    logic hsd, vsd, brd, hbd, vbd, lsd, fsd;

    vga_timing_gen #(.CNT_W(4), .HVID(8), .HFP(2), .HSW(3), .HBP(3), .VVID(4), .VFP(1), .VSW(2), .VBP(1),
                     .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(0)) u_s0 (
        .clock(clock), .clear(clear), .pixEn(pixEn), .hCount(h0), .vCount(v0), .hSync(hs0), .vSync(vs0),
        .bright(br0), .hBlank(hb0), .vBlank(vb0), .lineStart(ls0), .frameStart(fs0));

    vga_timing_gen #(.CNT_W(5), .HVID(8), .HFP(2), .HSW(3), .HBP(3), .VVID(4), .VFP(1), .VSW(2), .VBP(1),
                     .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DLY(3)) u_s3 (
        .clock(clock), .clear(clear), .pixEn(pixEn), .hCount(h3), .vCount(v3), .hSync(hs3), .vSync(vs3),
        .bright(br3), .hBlank(hb3), .vBlank(vb3), .lineStart(ls3), .frameStart(fs3));

    vga_timing_gen #(.CNT_W(4), .HVID(8), .HFP(2), .HSW(3), .HBP(3), .VVID(4), .VFP(1), .VSW(2), .VBP(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DLY(0)) u_p (
        .clock(clock), .clear(clear), .pixEn(pixEn), .hCount(hp), .vCount(vp), .hSync(hsp), .vSync(vsp),
        .bright(brp), .hBlank(hbp), .vBlank(vbp), .lineStart(lsp), .frameStart(fsp));

    vga_timing_gen #(.PIPE_DLY(2)) u_d (
        .clock(clock), .clear(clear), .pixEn(pixEn), .hCount(hd), .vCount(vd), .hSync(hsd), .vSync(vsd),
        .bright(brd), .hBlank(hbd), .vBlank(vbd), .lineStart(lsd), .frameStart(fsd));

    typedef struct {
        int h;
        int v;
        bit hs, vs, br, hb, vb, ls, fs;
    } exp_t;

    // n = pixel ticks since clear; outputs reflect raster position n-d, flushed before that.
    function automatic exp_t model(input int t, input int d, input int hv, input int hfp, input int hsw,
                                   input int hbk, input int vv, input int vfp, input int vsw, input int vbk,
                                   input bit hpol, input bit vpol, input bit pe);
        exp_t e;
        int ht, vt, m, h, v;
        ht = hv + hfp + hsw + hbk;
        vt = vv + vfp + vsw + vbk;
        e.h = t % ht;
        e.v = (t / ht) % vt;
        e.hs = !hpol; e.vs = !vpol; e.br = 0; e.hb = 0; e.vb = 0; e.ls = 0; e.fs = 0;
        if (t >= d) begin
            m = t - d;
            h = m % ht;
            v = (m / ht) % vt;
            e.hs = (h >= hv + hfp && h < hv + hfp + hsw) ? hpol : !hpol;
            e.vs = (v >= vv + vfp && v < vv + vfp + vsw) ? vpol : !vpol;
            e.br = h < hv && v < vv;
            e.hb = h >= hv;
            e.vb = v >= vv;
            e.ls = pe && h == 0;
            e.fs = pe && h == 0 && v == 0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input int h, input int v, input bit hs, input bit vs,
                       input bit br, input bit hb, input bit vb, input bit ls, input bit fs);
        chk({tag, ".hCount"}, h, e.h);
        chk({tag, ".vCount"}, v, e.v);
        chk({tag, ".hSync"}, int'(hs), int'(e.hs));
        chk({tag, ".vSync"}, int'(vs), int'(e.vs));
        chk({tag, ".bright"}, int'(br), int'(e.br));
        chk({tag, ".hBlank"}, int'(hb), int'(e.hb));
        chk({tag, ".vBlank"}, int'(vb), int'(e.vb));
        chk({tag, ".lineStart"}, int'(ls), int'(e.ls));
        chk({tag, ".frameStart"}, int'(fs), int'(e.fs));
    endtask

    always @(posedge clock) begin
        if (clear) begin
            n <= 0;
            armed <= 1'b1;
        end else if (pixEn) begin
            n <= n + 1;
        end
    end

    always @(negedge clock) begin
        if (armed && !clear) begin
            cmp("s0", model(n, 0, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0, pixEn),
                int'(h0), int'(v0), hs0, vs0, br0, hb0, vb0, ls0, fs0);
            cmp("s3", model(n, 3, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0, pixEn),
                int'(h3), int'(v3), hs3, vs3, br3, hb3, vb3, ls3, fs3);
            cmp("pol", model(n, 0, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1, pixEn),
                int'(hp), int'(vp), hsp, vsp, brp, hbp, vbp, lsp, fsp);
            cmp("def", model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, pixEn),
                int'(hd), int'(vd), hsd, vsd, brd, hbd, vbd, lsd, fsd);
        end
    end

    task automatic tick(input bit pe, input bit clr);
        @(posedge clock);
        #1;
        pixEn = pe;
        clear = clr;
    endtask

    initial begin
        int t_hs = -1, t_hs3 = -1, t_hsp = -1, fs_a = -1, fs_b = -1, vs_low = 0, hs_low = 0, bad = 0;
        int found = 0;
        int lsq[$];
        int lsq2[$];
        repeat (2) tick(1'b0, 1'b1);
        for (int i = 0; i < 1700; i++) begin
            tick(1'b1, 1'b0);
            @(negedge clock);
            if (i == 0) begin
                chk("T1_bright_at_origin", int'(br0), 1);
                chk("T3_flushed_bright", int'(br3), 0);
                chk("T3_flushed_hsync", int'(hs3), 1);
                chk("T3_flushed_vsync", int'(vs3), 1);
                chk("T6_idle_hsync", int'(hsp), 0);
                chk("T6_idle_vsync", int'(vsp), 0);
            end
            if (t_hs < 0 && !hs0) t_hs = i;
            if (t_hs3 < 0 && !hs3) t_hs3 = i;
            if (t_hsp < 0 && hsp) t_hsp = i;
            if (i < 16 && !hs0) hs_low++;
            if (i < 128 && !vs0) vs_low++;
            if (fs0) begin
                if (fs_a < 0) fs_a = i;
                else if (fs_b < 0) fs_b = i;
            end
            if (lsd) lsq.push_back(i);
        end
        chk("T1_hsync_first_low", t_hs, 10);
        chk("T1_hsync_low_width", hs_low, 3);
        chk("T1_vsync_low_clocks", vs_low, 32);
        chk("T1_frame_first", fs_a, 0);
        chk("T1_frame_period", fs_b - fs_a, 128);
        chk("T3_hsync_fall_tick", t_hs3, 13);
        chk("T6_hsync_first_high", t_hsp, 10);
        chk("T4_line_count", lsq.size(), 3);
        if (lsq.size() == 3) begin
            chk("T4_line_first", lsq[0], 2);
            chk("T4_line_period_a", lsq[1] - lsq[0], 800);
            chk("T4_line_period_b", lsq[2] - lsq[1], 800);
        end

        tick(1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            tick(i % 2 == 0, 1'b0);
            @(negedge clock);
            if (ls0) begin
                lsq2.push_back(i);
                if (i % 2 == 1) bad++;
            end
        end
        chk("T2_line_count", lsq2.size(), 8);
        chk("T2_line_on_idle_clock", bad, 0);
        if (lsq2.size() >= 2) chk("T2_line_period", lsq2[1] - lsq2[0], 32);

        for (int i = 0; i < 4000; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);

        tick(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 1'b0);
            @(negedge clock);
            if (h0 == 4'd5 && v0 == 4'd6) begin
                found = 1;
                break;
            end
        end
        chk("T5_reached_5_6", found, 1);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        @(negedge clock);
        chk("T5_hcount_zero", int'(h0), 0);
        chk("T5_vcount_zero", int'(v0), 0);
        chk("T5_hsync_idle", int'(hs0), 1);
        chk("T5_vsync_idle", int'(vs0), 1);
        chk("T5_line_quiet", int'(ls0), 0);
        chk("T5_frame_quiet", int'(fs0), 0);
        chk("T5_dly_bright", int'(br3), 0);
        chk("T5_pol_hsync_idle", int'(hsp), 0);
        tick(1'b1, 1'b0);
        @(negedge clock);
        chk("T5_first_line", int'(ls0), 1);
        chk("T5_first_frame", int'(fs0), 1);
        chk("T5_dly_line_flushed", int'(ls3), 0);
        repeat (40) tick(1'b1, 1'b0);
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
